// File: rtl/maze_pkg.sv
// Shared definitions for the maze path stream: grid size, step directions,
// the run-length token layout and the encoder state encodings.
package maze_pkg;

    localparam int MAZE_WIDTH = 17;
    localparam int LEN_WIDTH  = 5;

    localparam logic [1:0] RIGHT = 2'd0;
    localparam logic [1:0] DOWN  = 2'd1;
    localparam logic [1:0] LEFT  = 2'd2;
    localparam logic [1:0] UP    = 2'd3;

    typedef struct packed {
        logic [1:0]           dir;
        logic [LEN_WIDTH-1:0] len;
        logic                 last;
    } path_tok_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } enc_state_t;

endpackage

// File: rtl/path_tok_fifo.sv
// Synchronous token FIFO. Pointers carry an extra wrap bit so full/empty come
// from an MSB compare; a push into a full FIFO only lands if a pop frees a slot.
module path_tok_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately unreset; empty pointers make stale contents unobservable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/path_rle_encoder.sv
// Run-length encoder for the maze solver direction stream: tracks the walker
// position, packs equal-direction runs into tokens and drains them via valid/ready.
module path_rle_encoder #(
    parameter int MAZE_WIDTH = maze_pkg::MAZE_WIDTH,
    parameter int LEN_WIDTH  = maze_pkg::LEN_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [1:0]           in_dir,
    output logic                 tok_valid,
    input  logic                 tok_ready,
    output logic [1:0]           tok_dir,
    output logic [LEN_WIDTH-1:0] tok_len,
    output logic                 tok_last,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] step_count,
    output logic                 err_oob,
    output logic                 err_end,
    output logic                 err_ovf
);
    import maze_pkg::*;

    localparam int                   CW      = $clog2(MAZE_WIDTH);
    localparam logic [CW-1:0]        GOAL    = CW'(MAZE_WIDTH - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef logic signed [CW:0] coord_t;
    localparam coord_t COORD_MAX = coord_t'(MAZE_WIDTH - 1);

    typedef struct packed {
        logic [1:0]           dir;
        logic [LEN_WIDTH-1:0] len;
        logic                 last;
    } tok_t;

    enc_state_t           state;
    enc_state_t           state_nxt;
    logic [CW-1:0]        pos_x;
    logic [CW-1:0]        pos_y;
    logic [CW-1:0]        nxt_x;
    logic [CW-1:0]        nxt_y;
    coord_t               sx;
    coord_t               sy;
    logic                 step_oob;
    logic [1:0]           run_dir;
    logic [LEN_WIDTH-1:0] run_len;
    logic                 start;
    logic                 step;
    logic                 extend;
    logic                 finish;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    tok_t                 push_tok;
    tok_t                 head_tok;

    // A new path always steps from the origin, whatever the last path left behind.
    always_comb begin
        sx = (state == IDLE) ? coord_t'(0) : coord_t'({1'b0, pos_x});
        sy = (state == IDLE) ? coord_t'(0) : coord_t'({1'b0, pos_y});
        case (in_dir)
            RIGHT:   sy = sy + coord_t'(1);
            DOWN:    sx = sx + coord_t'(1);
            LEFT:    sy = sy - coord_t'(1);
            default: sx = sx - coord_t'(1);
        endcase
        step_oob = 1'b0;
        nxt_x    = sx[CW-1:0];
        nxt_y    = sy[CW-1:0];
        if (sx < coord_t'(0)) begin
            nxt_x    = '0;
            step_oob = 1'b1;
        end else if (sx > COORD_MAX) begin
            nxt_x    = GOAL;
            step_oob = 1'b1;
        end
        if (sy < coord_t'(0)) begin
            nxt_y    = '0;
            step_oob = 1'b1;
        end else if (sy > COORD_MAX) begin
            nxt_y    = GOAL;
            step_oob = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        step      = 1'b0;
        extend    = 1'b0;
        finish    = 1'b0;
        push      = 1'b0;
        push_tok  = '0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    step = 1'b1;
                    if (in_dir == run_dir && run_len != LEN_MAX) begin
                        extend = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_tok = '{dir: run_dir, len: run_len, last: 1'b0};
                    end
                end else begin
                    push      = 1'b1;
                    push_tok  = '{dir: run_dir, len: run_len, last: 1'b1};
                    finish    = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x      <= '0;
            pos_y      <= '0;
            run_dir    <= RIGHT;
            run_len    <= '0;
            step_count <= '0;
            err_oob    <= 1'b0;
            err_end    <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            if (start) begin
                pos_x      <= nxt_x;
                pos_y      <= nxt_y;
                run_dir    <= in_dir;
                run_len    <= LEN_ONE;
                step_count <= CNT_ONE;
                err_oob    <= step_oob;
                err_end    <= 1'b0;
                err_ovf    <= 1'b0;
            end else if (step) begin
                pos_x   <= nxt_x;
                pos_y   <= nxt_y;
                run_dir <= in_dir;
                run_len <= extend ? run_len + LEN_ONE : LEN_ONE;
                if (step_count != '1) step_count <= step_count + CNT_ONE;
                if (step_oob)         err_oob    <= 1'b1;
            end
            // The end check uses the position reached by the final accepted step.
            if (finish) begin
                err_end <= (pos_x != GOAL) || (pos_y != GOAL);
                run_len <= '0;
            end
            if (push && fifo_full && !pop) err_ovf <= 1'b1;
        end
    end

    path_tok_fifo #(
        .WIDTH ($bits(tok_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_tok),
        .pop   (pop),
        .dout  (head_tok),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tok_valid = !fifo_empty;
    assign pop       = tok_valid && tok_ready;
    assign tok_dir   = head_tok.dir;
    assign tok_len   = head_tok.len;
    assign tok_last  = head_tok.last;

endmodule

// File: tb/tb_path_rle_encoder.sv
// Scoreboard bench for path_rle_encoder: a path-level model queues expected
// tokens and end-of-path flags; a monitor checks every token handshake.
module tb_path_rle_encoder;
    import maze_pkg::*;

    localparam int LW   = maze_pkg::LEN_WIDTH;
    localparam int CNTW = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [1:0]      in_dir = 2'd0;
    logic            tok_valid;
    logic            tok_ready = 1'b0;
    logic [1:0]      tok_dir;
    logic [LW-1:0]   tok_len;
    logic            tok_last;
    logic            done;
    logic [CNTW-1:0] step_count;
    logic            err_oob;
    logic            err_end;
    logic            err_ovf;

    path_rle_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_dir     (in_dir),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_dir    (tok_dir),
        .tok_len    (tok_len),
        .tok_last   (tok_last),
        .done       (done),
        .step_count (step_count),
        .err_oob    (err_oob),
        .err_end    (err_end),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    int         cycle = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         ready_mode = 1;   // 0: held low, 1: held high, 2: random but high every other cycle
    int         fall_cycle = 0;
    int         done_cycle = 0;
    int         exp_cnt = 0;
    logic       exp_oob;
    logic       exp_end;
    logic [1:0] path_q[$];
    path_tok_t  exp_q[$];
    path_tok_t  mon_exp;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    endtask

    // Token scoreboard: every accepted token must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && tok_valid && tok_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_token", {tok_dir, tok_len, tok_last}, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("token", {24'd0, tok_dir, tok_len, tok_last}, {24'd0, mon_exp});
            end
        end
    end

    // Path-level reference: split into maximal equal-direction runs capped at 31,
    // walk the grid with clamping, and queue at most max_tok tokens.
    task automatic model_path(input int max_tok);
        int x = 0;
        int y = 0;
        int i = 0;
        int n = path_q.size();
        int taken = 0;
        int len;
        logic [1:0] d;
        path_tok_t t;
        exp_oob = 1'b0;
        foreach (path_q[k]) begin
            case (path_q[k])
                2'd0: y++;
                2'd1: x++;
                2'd2: y--;
                default: x--;
            endcase
            if (x < 0) begin x = 0; exp_oob = 1'b1; end
            if (y < 0) begin y = 0; exp_oob = 1'b1; end
            if (x > MAZE_WIDTH - 1) begin x = MAZE_WIDTH - 1; exp_oob = 1'b1; end
            if (y > MAZE_WIDTH - 1) begin y = MAZE_WIDTH - 1; exp_oob = 1'b1; end
        end
        exp_end = !(x == MAZE_WIDTH - 1 && y == MAZE_WIDTH - 1);
        exp_cnt = (n > 511) ? 511 : n;
        while (i < n) begin
            d   = path_q[i];
            len = 0;
            while (i < n && path_q[i] == d && len < 31) begin
                len++;
                i++;
            end
            if (taken < max_tok) begin
                t.dir  = d;
                t.len  = LW'(len);
                t.last = (i == n);
                exp_q.push_back(t);
                taken++;
            end
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       tok_ready = 1'b0;
            1:       tok_ready = 1'b1;
            default: tok_ready = (cycle % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic drive_path(input int ready_on_beat);
        for (int i = 0; i < path_q.size(); i++) begin
            if (i == ready_on_beat) ready_mode = 1;
            step_cycle();
            in_valid = 1'b1;
            in_dir   = path_q[i];
        end
        step_cycle();
        in_valid   = 1'b0;
        fall_cycle = cycle;
    endtask

    task automatic wait_done(input logic want_ovf, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                seen       = 1'b1;
                done_cycle = cycle;
                break;
            end
            step_cycle();
        end
        check("done_seen", seen, 1);
        if (seen) begin
            check("step_count", step_count, exp_cnt);
            check("err_oob", err_oob, exp_oob);
            check("err_end", err_end, exp_end);
            check("err_ovf", err_ovf, want_ovf);
            check("tokens_outstanding", exp_q.size(), 0);
        end
    endtask

    task automatic push_run(input logic [1:0] d, input int len);
        for (int i = 0; i < len; i++) path_q.push_back(d);
    endtask

    task automatic clean_path_and_latency();
        path_q.delete();
        push_run(RIGHT, 16);
        push_run(DOWN, 16);
        model_path(1000);
        ready_mode = 1;
        drive_path(-1);
        wait_done(1'b0, 100);
        check("done_latency", done_cycle - fall_cycle, 2);
        step_cycle();
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int prev;
        int d;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tok", {tok_valid, tok_dir, tok_len, tok_last}, 0);
        check("rst_done", done, 0);
        check("rst_step_count", step_count, 0);
        check("rst_errs", {err_oob, err_end, err_ovf}, 0);
        rst_n = 1'b1;

        // Clean corner-to-corner path, including done latency.
        clean_path_and_latency();

        // 40 RIGHT: splits at the 31 cap and runs off the grid.
        path_q.delete();
        push_run(RIGHT, 40);
        model_path(1000);
        drive_path(-1);
        wait_done(1'b0, 100);

        // Single UP from the origin.
        path_q.delete();
        push_run(UP, 1);
        model_path(1000);
        drive_path(-1);
        wait_done(1'b0, 100);

        // Alternating R,D with the consumer stalled: only 8 tokens survive.
        path_q.delete();
        for (int i = 0; i < 16; i++) begin
            push_run(RIGHT, 1);
            push_run(DOWN, 1);
        end
        model_path(8);
        ready_mode = 0;
        drive_path(-1);
        repeat (4) step_cycle();
        @(negedge clk);
        check("ovf_while_stalled", err_ovf, 1);
        check("no_done_while_full", done, 0);
        ready_mode = 1;
        wait_done(1'b1, 200);

        // FIFO full, then push and pop in the same cycle: nothing is lost.
        path_q.delete();
        for (int i = 0; i < 5; i++) begin
            push_run(RIGHT, 1);
            push_run(DOWN, 1);
        end
        model_path(1000);
        ready_mode = 0;
        drive_path(9);
        wait_done(1'b0, 100);

        // Reset mid-path with tokens buffered.
        path_q.delete();
        path_q = '{RIGHT, RIGHT, DOWN, DOWN, LEFT};
        ready_mode = 0;
        foreach (path_q[i]) begin
            step_cycle();
            in_valid = 1'b1;
            in_dir   = path_q[i];
        end
        @(posedge clk);
        #2;
        check("pre_reset_tok_valid", tok_valid, 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_rst_tok", {tok_valid, tok_dir, tok_len, tok_last}, 0);
        check("async_rst_count", step_count, 0);
        check("async_rst_done", done, 0);
        step_cycle();
        rst_n = 1'b1;
        exp_q.delete();
        clean_path_and_latency();

        // Saturating step counter.
        path_q.delete();
        for (int i = 0; i < 26; i++) push_run(2'(i % 4), 20);
        model_path(1000);
        ready_mode = 1;
        drive_path(-1);
        wait_done(1'b0, 200);

        // Random paths with runs of at least two beats and intermittent backpressure.
        for (int p = 0; p < 6; p++) begin
            path_q.delete();
            prev = 4;
            for (int r = 0; r < int'($urandom_range(1, 6)); r++) begin
                do d = int'($urandom_range(0, 3)); while (d == prev);
                push_run(2'(d), int'($urandom_range(2, 40)));
                prev = d;
            end
            model_path(1000);
            ready_mode = 2;
            drive_path(-1);
            wait_done(1'b0, 600);
            repeat (2) step_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/path_rle_encoder.md
Name: path_rle_encoder

Overview:
- Downstream consumer of the maze solver's direction stream. The solver emits one 2-bit direction per cycle while out_valid is high (RIGHT=0, DOWN=1, LEFT=2, UP=3).
- This block does three things:
  - tracks the walker position from (0,0) on the 17x17 grid;
  - run-length encodes consecutive equal directions into (dir, len, last) tokens;
  - buffers the tokens in a small FIFO and drains them over a valid/ready handshake.
- It also flags path errors: out-of-bounds step, wrong end cell, and FIFO overflow.

Parameters:
- MAZE_WIDTH, 17: grid side; legal coordinates 0..MAZE_WIDTH-1; goal cell is (MAZE_WIDTH-1, MAZE_WIDTH-1).
- LEN_WIDTH, 5: run-length field width; the maximum run per token is 2^LEN_WIDTH-1 (31).
- FIFO_DEPTH, 8: token FIFO entries; must be a power of 2.
- CNT_WIDTH, 9: step counter width; saturates at all-ones.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: direction beat valid; the solver's out_valid. No backpressure; a beat is accepted every cycle it is high.
- in_dir, input, 2: direction of the step; the solver's out.
- tok_valid, output, 1: FIFO head token valid.
- tok_ready, input, 1: consumer accepts the token on tok_valid && tok_ready.
- tok_dir, output, 2: token direction.
- tok_len, output, LEN_WIDTH: run length, 1..31.
- tok_last, output, 1: final token of the path.
- done, output, 1: one-cycle pulse once the stream has ended and the FIFO is fully drained.
- step_count, output, CNT_WIDTH: steps accepted in the current or last path.
- err_oob, output, 1: sticky; some step left the grid.
- err_end, output, 1: sticky; the final position is not the goal. Valid from the done pulse onward.
- err_ovf, output, 1: sticky; a token was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - all outputs 0; tok_* driven 0 while the FIFO is empty;
  - FIFO empty; position (0,0); run length 0; state IDLE.
- States:
  - IDLE: in_valid=1 starts a path, which
    - clears step_count and all err_*;
    - sets position (0,0);
    - loads run_dir=in_dir, run_len=1 and applies that step;
    - moves to RUN.
  - RUN, on a cycle with in_valid=1:
    - if in_dir==run_dir and run_len<31: run_len+1;
    - otherwise push token {run_dir, run_len, last=0} and load run_dir=in_dir, run_len=1;
    - in both cases apply the step and increment step_count.
  - RUN, on the first cycle with in_valid=0: push {run_dir, run_len, last=1}, evaluate err_end from the current position, go to DRAIN.
  - DRAIN: wait for the FIFO to empty. In the cycle it is empty (no push pending), pulse done=1 and go to IDLE.
  - in_valid=1 while in DRAIN is ignored (protocol violation; the solver guarantees gaps between paths).
- Position update: RIGHT y+1, DOWN x+1, LEFT y-1, UP x-1. The arithmetic is signed and one bit wider than the coordinate.
- Out-of-bounds steps:
  - any result <0 or >MAZE_WIDTH-1 sets err_oob;
  - the position clamps at the boundary;
  - encoding continues.
- err_end = position != (16,16), set at the last-token push.
- Token timing: a token pushed in cycle N is visible on tok_valid in cycle N+1. A pop happens at the clock edge where tok_valid && tok_ready.
- Full FIFO:
  - a push and a pop in the same cycle both succeed;
  - a push on a full FIFO with no pop drops the token and sets err_ovf;
  - occupancy never exceeds FIFO_DEPTH.
- Empty FIFO: tok_valid=0, and tok_ready is ignored.
- Wrap-around: the FIFO pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty come from an MSB compare.
- step_count saturates and does not wrap.
- Reset asserted mid-path returns everything to its reset values immediately (asynchronously). Partial runs are discarded.

Decomposition:
- Package maze_pkg holds:
  - MAZE_WIDTH;
  - direction constants RIGHT/DOWN/LEFT/UP (2-bit);
  - the path token type {dir[1:0], len[LEN_WIDTH-1:0], last};
  - state encodings IDLE/RUN/DRAIN.
- One sub-module: path_tok_fifo, a synchronous FIFO with push/pop/full/empty, parameterised by width and depth.
- The encoder FSM, position tracker and error flags stay in the top module.

Test Plan:
- Path of 16 RIGHT then 16 DOWN, tok_ready=1 throughout:
  - tokens (0,16,0) then (1,16,1);
  - step_count=32; err_*=0;
  - done pulses 2 cycles after in_valid falls.
- Path of 40 consecutive RIGHT (grid limit overridden): tokens (0,31,0) then (0,9,1); err_oob=1; err_end=1.
- Single beat UP:
  - err_oob=1; position stays (0,0);
  - one token (3,1,1); err_end=1; step_count=1.
- Alternating R,D x16 with tok_ready=0:
  - first 8 tokens are stored; later pushes are dropped and err_ovf=1;
  - raising tok_ready drains exactly 8 tokens, then done pulses.
- FIFO full with tok_ready=1 on the push cycle: push and pop both occur; count stays 8; err_ovf=0.
- rst_n pulsed low mid-RUN after 5 beats:
  - all outputs are 0 immediately;
  - the next path encodes cleanly from (0,0); no stale tokens appear.
